// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_rv register file and its response buffer.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

    typedef enum logic [1:0] {
        RSP_EMPTY = 2'd0,
        RSP_ONE   = 2'd1,
        RSP_FULL  = 2'd2
    } rsp_count_e;

    typedef logic [DEF_DATA_W-1:0]            operand_t;
    typedef logic [DEF_NUM_RD*DEF_DATA_W-1:0] operand_vec_t;

    function automatic int operand_vec_w(input int num_rd, input int data_w);
        return num_rd * data_w;
    endfunction

endpackage

// File: rtl/regfile_rv_rsp_skid_fifo.sv
// Two-entry response buffer; owns the occupancy state and both handshake outputs.
//   state     | meaning
//   RSP_EMPTY | no response held, rsp_valid low
//   RSP_ONE   | one response held, push and pop both allowed
//   RSP_FULL  | two responses held, push blocked
module rsp_skid_fifo
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    rsp_count_e       count_q, count_d;
    logic             push;
    logic             pop;

    // Ready is gated by reset so the producer sees it low while rst_ni is held.
    assign push_ready_o = rst_ni && (count_q != RSP_FULL);
    assign pop_valid_o  = (count_q != RSP_EMPTY);
    assign pop_data_o   = mem_q[rd_ptr_q];

    assign push = push_valid_i && push_ready_o;
    assign pop  = pop_valid_o && pop_ready_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = (count_q == RSP_EMPTY) ? RSP_ONE : RSP_FULL;
            2'b01:   count_d = (count_q == RSP_FULL) ? RSP_ONE : RSP_EMPTY;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= RSP_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/regfile_rv.sv
// Multi-read-port register file with a buffered valid/ready read channel and a free-running write port.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle write data into matching read ports.
module regfile_rv
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [NUM_RD*ADDR_W-1:0]   req_addr_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [NUM_RD*DATA_W-1:0]   rsp_data_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i
);

    localparam int OPS_W = operand_vec_w(NUM_RD, DATA_W);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [OPS_W-1:0]  ops_rd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = req_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rd_val = (rd_addr == '0) ? '0 :
                        (wr_en_i && (wr_addr_i == rd_addr)) ? wr_data_i : regs_q[rd_addr];
`else
        assign rd_val = (rd_addr == '0) ? '0 : regs_q[rd_addr];
`endif
        assign ops_rd[k*DATA_W +: DATA_W] = rd_val;
    end

    rsp_skid_fifo #(
        .WIDTH(OPS_W)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_valid_i(req_valid_i),
        .push_ready_o(req_ready_o),
        .push_data_i (ops_rd),
        .pop_valid_o (rsp_valid_o),
        .pop_ready_i (rsp_ready_i),
        .pop_data_o  (rsp_data_o)
    );

endmodule

// File: tb/tb_regfile_rv.sv
// Directed bench for regfile_rv (default parameters); inputs change and outputs are checked on the falling edge.
module tb_regfile_rv;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [9:0]  req_addr_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;

    int n_checks = 0;
    int n_fail   = 0;
    int idx;
    logic [31:0] byp_exp;

    always #5 clk_i = ~clk_i;

    regfile_rv dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        @(negedge clk_i);
        wr_en_i   = 1'b0;
    endtask

    // One request with rsp_ready_i high; checks the response in the following cycle.
    task automatic do_read(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [63:0] exp);
        req_valid_i = 1'b1;
        req_addr_i  = {a1, a0};
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
        check_eq({tag, "_data"}, rsp_data_o, exp);
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        rsp_ready_i = 1'b1;
        wr_en_i     = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_ready", 64'(req_ready_o), 64'd0);
        check_eq("rst_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_data", rsp_data_o, 64'd0);
        rst_ni = 1'b1;
        #1;
        check_eq("rel_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);

        wr(5'd5, 32'hDEADBEEF);
        do_read("rd_x5", 5'd5, 5'd0, {32'h0, 32'hDEADBEEF});
        wr(5'd0, 32'h1234);
        do_read("rd_x0", 5'd0, 5'd0, 64'd0);
        @(negedge clk_i);
        check_eq("idle_valid", 64'(rsp_valid_o), 64'd0);

        for (int i = 1; i <= 16; i++) wr(5'(i), 32'(i * 3));
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) begin
                req_valid_i = 1'b1;
                req_addr_i  = {5'd0, 5'(i)};
                check_eq("stream_ready", 64'(req_ready_o), 64'd1);
            end else begin
                req_valid_i = 1'b0;
            end
            if (i > 1) begin
                check_eq("stream_valid", 64'(rsp_valid_o), 64'd1);
                check_eq("stream_data", rsp_data_o, 64'((i - 1) * 3));
            end
            @(negedge clk_i);
        end
        check_eq("stream_done", 64'(rsp_valid_o), 64'd0);

        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        idx = 1;
        for (int c = 0; c < 4; c++) begin
            req_addr_i = {5'd0, 5'(idx)};
            check_eq("bp_ready", 64'(req_ready_o), (c < 2) ? 64'd1 : 64'd0);
            if (req_ready_o) idx++;
            @(negedge clk_i);
        end
        check_eq("bp_accepted", 64'(idx), 64'd3);
        check_eq("bp_head0", rsp_data_o, 64'd3);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("bp_head1", rsp_data_o, 64'd6);
        check_eq("bp_ready_back", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        check_eq("bp_drained", 64'(rsp_valid_o), 64'd0);
        do_read("bp_resume", 5'd3, 5'd0, 64'd9);

        wr(5'd7, 32'h11);
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h11;
`endif
        wr_en_i     = 1'b1;
        wr_addr_i   = 5'd7;
        wr_data_i   = 32'hA5A5A5A5;
        req_valid_i = 1'b1;
        req_addr_i  = {5'd7, 5'd7};
        @(negedge clk_i);
        wr_en_i     = 1'b0;
        req_valid_i = 1'b0;
        check_eq("byp_same", rsp_data_o, {byp_exp, byp_exp});
        do_read("byp_after", 5'd7, 5'd7, {32'hA5A5A5A5, 32'hA5A5A5A5});
        wr_en_i     = 1'b1;
        wr_addr_i   = 5'd0;
        wr_data_i   = 32'hFFFF;
        req_valid_i = 1'b1;
        req_addr_i  = {5'd0, 5'd0};
        @(negedge clk_i);
        wr_en_i     = 1'b0;
        req_valid_i = 1'b0;
        check_eq("byp_x0", rsp_data_o, 64'd0);
        @(negedge clk_i);

        wr(5'd9, 32'h10);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = {5'd0, 5'd9};
        @(negedge clk_i);
        req_valid_i = 1'b0;
        wr(5'd9, 32'h20);
        check_eq("snap_hold0", rsp_data_o, 64'h10);
        @(negedge clk_i);
        check_eq("snap_hold1", rsp_data_o, 64'h10);
        check_eq("snap_valid", 64'(rsp_valid_o), 64'd1);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("snap_popped", 64'(rsp_valid_o), 64'd0);
        do_read("snap_new", 5'd9, 5'd0, 64'h20);

        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = {5'd0, 5'd1};
        @(negedge clk_i);
        req_addr_i  = {5'd0, 5'd2};
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq("full_ready", 64'(req_ready_o), 64'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mrst_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("mrst_ready", 64'(req_ready_o), 64'd0);
        check_eq("mrst_data", rsp_data_o, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        check_eq("mrel_ready", 64'(req_ready_o), 64'd1);
        check_eq("mrel_valid", 64'(rsp_valid_o), 64'd0);
        @(negedge clk_i);
        for (int i = 1; i < 32; i++) do_read("clr", 5'(i), 5'(i), 64'd0);
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
